// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures a slow periodic signal (for example a divided clock or an external
// strobe) against the fast system clock clk_in. Each rising edge of sig_in
// closes one measurement: the rise-to-rise period and the number of cycles the
// signal was high inside that period are published together with a one-cycle
// valid strobe. A lock flag rises once LOCK_COUNT consecutive periods land
// inside EXPECTED +/- TOLERANCE. If no rising edge arrives before the period
// counter saturates, a sticky overflow flag is raised and the meter falls back
// to waiting for a fresh edge.
//
// Parameters
//   CNT_W      width of the period/high counters and of period_out/high_out
//   EXPECTED   nominal period in clk_in cycles used for the lock decision
//   TOLERANCE  allowed |period - EXPECTED| for a period to count as matching
//   LOCK_COUNT consecutive matching periods needed for locked_out (1..15)
//
// Optional build feature (macro PERIOD_METER_DUTY_EN)
//   When defined, an extra output duty_ok_out reports whether the measured
//   period was close to 50% duty, and a period only counts as matching when
//   both the period and the duty checks pass. When undefined, the port does
//   not exist and lock depends on the period alone.
//
// Ports
//   clk_in        in   system clock, all logic on its rising edge
//   rst_in        in   synchronous active-high reset
//   sig_in        in   asynchronous slow input signal
//   period_out    out  last measured rise-to-rise period in clk_in cycles
//   high_out      out  cycles sig_in was high within that period
//   valid_out     out  one-cycle strobe, period_out/high_out updated this cycle
//   locked_out    out  LOCK_COUNT consecutive matching periods seen
//   duty_ok_out   out  (PERIOD_METER_DUTY_EN only) last period near 50% duty
//   overflow_out  out  sticky, period counter saturated without an edge
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int CNT_W      = 16,
    parameter int EXPECTED   = 10,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid_out,
    output logic             locked_out,
`ifdef PERIOD_METER_DUTY_EN
    output logic             duty_ok_out,
`endif
    output logic             overflow_out
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wide_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam cnt_t        CNT_ONE_C = cnt_t'(32'd1);
    localparam cnt_t        CNT_MAX_C = {CNT_W{1'b1}};
    // Lower bound clamps at zero so a large tolerance cannot wrap around.
    localparam logic [31:0] LO_C      = (EXPECTED > TOLERANCE) ?
                                        32'(EXPECTED - TOLERANCE) : 32'd0;
    localparam logic [31:0] HI_C      = 32'(EXPECTED + TOLERANCE);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_COUNT);

    // True when value lies inside the closed window [lo, hi].
    function automatic logic in_window(input logic [31:0] value,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

    // Increment that sticks at limit instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt,
                                           input logic [3:0] limit);
        logic [3:0] result;
        if (cnt >= limit) begin
            result = limit;
        end else begin
            result = cnt + 4'd1;
        end
        return result;
    endfunction

`ifdef PERIOD_METER_DUTY_EN
    // Duty window: |2*high - period| <= 2*TOLERANCE + 1, at CNT_W+1 bits.
    localparam wide_t DUTY_LIM_C = wide_t'(32'd2 * 32'(TOLERANCE) + 32'd1);

    // Magnitude of a - b without needing a signed representation.
    function automatic wide_t abs_diff(input wide_t a, input wide_t b);
        wide_t result;
        if (a >= b) begin
            result = a - b;
        end else begin
            result = b - a;
        end
        return result;
    endfunction
`endif

    logic       sync1_r;
    logic       sync2_r;
    logic       hist_r;
    state_t     state_r;
    cnt_t       period_cnt_r;
    cnt_t       high_cnt_r;
    logic [3:0] match_cnt_r;

    logic       rise_s;
    logic       period_ok_s;
    logic       match_s;
    logic [3:0] match_next_s;
`ifdef PERIOD_METER_DUTY_EN
    wide_t      duty_diff_s;
    logic       duty_ok_s;
`endif

    // Edge detect and match evaluation on the counts being closed this cycle.
    always_comb begin
        rise_s      = sync2_r & ~hist_r;
        period_ok_s = in_window(32'(period_cnt_r), LO_C, HI_C);
`ifdef PERIOD_METER_DUTY_EN
        duty_diff_s = abs_diff({high_cnt_r, 1'b0}, {1'b0, period_cnt_r});
        duty_ok_s   = (duty_diff_s <= DUTY_LIM_C);
        match_s     = period_ok_s & duty_ok_s;
`else
        match_s     = period_ok_s;
`endif
        if (match_s) begin
            match_next_s = sat_inc(match_cnt_r, LOCK_C);
        end else begin
            match_next_s = 4'd0;
        end
    end

    // Synchronizer, measurement FSM, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            hist_r       <= 1'b0;
            state_r      <= ST_IDLE;
            period_cnt_r <= '0;
            high_cnt_r   <= '0;
            match_cnt_r  <= 4'd0;
            period_out   <= '0;
            high_out     <= '0;
            valid_out    <= 1'b0;
            locked_out   <= 1'b0;
            overflow_out <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
            duty_ok_out  <= 1'b0;
`endif
        end else begin
            sync1_r   <= sig_in;
            sync2_r   <= sync1_r;
            hist_r    <= sync2_r;
            valid_out <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // The first edge only opens a window; nothing to report.
                    if (rise_s) begin
                        period_cnt_r <= CNT_ONE_C;
                        high_cnt_r   <= CNT_ONE_C;
                        state_r      <= ST_MEASURE;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end

                ST_MEASURE: begin
                    if (rise_s) begin
                        // Close the window and open the next one; the rise
                        // cycle itself is the first (high) cycle of the next.
                        period_out   <= period_cnt_r;
                        high_out     <= high_cnt_r;
                        valid_out    <= 1'b1;
                        period_cnt_r <= CNT_ONE_C;
                        high_cnt_r   <= CNT_ONE_C;
                        match_cnt_r  <= match_next_s;
                        locked_out   <= (match_next_s == LOCK_C);
`ifdef PERIOD_METER_DUTY_EN
                        duty_ok_out  <= duty_ok_s;
`endif
                    end else if (period_cnt_r == CNT_MAX_C) begin
                        // No edge in a full counter span: the reference is
                        // lost, so drop lock and wait for a fresh edge.
                        overflow_out <= 1'b1;
                        locked_out   <= 1'b0;
                        match_cnt_r  <= 4'd0;
                        state_r      <= ST_IDLE;
                    end else begin
                        period_cnt_r <= period_cnt_r + CNT_ONE_C;
                        if (sync2_r) begin
                            high_cnt_r <= high_cnt_r + CNT_ONE_C;
                        end else begin
                            high_cnt_r <= high_cnt_r;
                        end
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    period_cnt_r <= '0;
                    high_cnt_r   <= '0;
                    match_cnt_r  <= 4'd0;
                    locked_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Three period_meter instances share one stimulus stream:
//   u_a  CNT_W=16 EXPECTED=10 TOLERANCE=0
//   u_b  CNT_W=16 EXPECTED=12 TOLERANCE=0
//   u_c  CNT_W=6  EXPECTED=10 TOLERANCE=1
// A behavioural model derives expected outputs from the history of sig_in
// samples: the period is the distance between rising samples, the high time is
// the count of high samples between them, and results appear two cycles after
// the rising sample. Directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_period_meter;

    localparam int NI   = 3;
    localparam int LC   = 4;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] a_per, a_high, b_per, b_high;
    logic [5:0]  c_per, c_high;
    logic a_valid, a_lock, a_ovf, b_valid, b_lock, b_ovf, c_valid, c_lock, c_ovf;
`ifdef PERIOD_METER_DUTY_EN
    logic a_duty, b_duty, c_duty;
`endif

    period_meter #(.CNT_W(16), .EXPECTED(10), .TOLERANCE(0), .LOCK_COUNT(LC)) u_a (
        .clk_in(clk), .rst_in(rst), .sig_in(sig),
        .period_out(a_per), .high_out(a_high), .valid_out(a_valid),
        .locked_out(a_lock),
`ifdef PERIOD_METER_DUTY_EN
        .duty_ok_out(a_duty),
`endif
        .overflow_out(a_ovf));

    period_meter #(.CNT_W(16), .EXPECTED(12), .TOLERANCE(0), .LOCK_COUNT(LC)) u_b (
        .clk_in(clk), .rst_in(rst), .sig_in(sig),
        .period_out(b_per), .high_out(b_high), .valid_out(b_valid),
        .locked_out(b_lock),
`ifdef PERIOD_METER_DUTY_EN
        .duty_ok_out(b_duty),
`endif
        .overflow_out(b_ovf));

    period_meter #(.CNT_W(6), .EXPECTED(10), .TOLERANCE(1), .LOCK_COUNT(LC)) u_c (
        .clk_in(clk), .rst_in(rst), .sig_in(sig),
        .period_out(c_per), .high_out(c_high), .valid_out(c_valid),
        .locked_out(c_lock),
`ifdef PERIOD_METER_DUTY_EN
        .duty_ok_out(c_duty),
`endif
        .overflow_out(c_ovf));

    int p_w[NI]   = '{16, 16, 6};
    int p_exp[NI] = '{10, 12, 10};
    int p_tol[NI] = '{0, 0, 1};

    // Model state per instance
    int m_per[NI], m_high[NI], m_ref[NI], m_cons[NI];
    bit m_meas[NI], m_valid[NI], m_lock[NI], m_ovf[NI], m_duty[NI];
    int vcnt[NI];

    bit samp[HMAX];
    int cyc      = 0;
    int last_rst = -1;

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Synchronized view of sig_in sample k: anything at or before a reset is 0.
    function automatic bit sv(input int k);
        if (k < 0 || k <= last_rst || k >= HMAX) return 1'b0;
        return samp[k];
    endfunction

    task automatic model_step(input int i, input int n);
        int  per, hc;
        bit  ok, duty;
        m_valid[i] = 1'b0;
        if (rst) begin
            m_per[i] = 0; m_high[i] = 0; m_lock[i] = 1'b0; m_ovf[i] = 1'b0;
            m_duty[i] = 1'b0; m_meas[i] = 1'b0; m_cons[i] = 0;
            return;
        end
        if (sv(n - 2) && !sv(n - 3)) begin
            if (m_meas[i]) begin
                per = n - m_ref[i];
                hc  = 0;
                for (int k = m_ref[i] - 2; k <= n - 3; k++) hc += int'(sv(k));
                m_per[i]   = per;
                m_high[i]  = hc;
                m_valid[i] = 1'b1;
                ok = (per >= p_exp[i] - p_tol[i]) && (per <= p_exp[i] + p_tol[i]);
                duty = ((2 * hc - per) <= 2 * p_tol[i] + 1) &&
                       ((per - 2 * hc) <= 2 * p_tol[i] + 1);
`ifdef PERIOD_METER_DUTY_EN
                m_duty[i] = duty;
                ok = ok && duty;
`endif
                m_cons[i] = ok ? m_cons[i] + 1 : 0;
                m_lock[i] = (m_cons[i] >= LC);
            end
            m_meas[i] = 1'b1;
            m_ref[i]  = n;
        end else if (m_meas[i] && (n - m_ref[i]) == (1 << p_w[i]) - 1) begin
            m_meas[i] = 1'b0;
            m_ovf[i]  = 1'b1;
            m_lock[i] = 1'b0;
            m_cons[i] = 0;
        end
    endtask

    // Model update on each posedge, every-cycle comparison on each negedge.
    initial begin
        int d_per[NI], d_high[NI];
        logic d_valid[NI], d_lock[NI], d_ovf[NI], d_duty[NI];
        string nm[NI];
        nm = '{"a", "b", "c"};
        forever begin
            @(posedge clk);
            if (cyc < HMAX) samp[cyc] = sig;
            if (rst) last_rst = cyc;
            for (int i = 0; i < NI; i++) model_step(i, cyc);
            cyc++;
            @(negedge clk);
            d_per   = '{int'(a_per), int'(b_per), int'(c_per)};
            d_high  = '{int'(a_high), int'(b_high), int'(c_high)};
            d_valid = '{a_valid, b_valid, c_valid};
            d_lock  = '{a_lock, b_lock, c_lock};
            d_ovf   = '{a_ovf, b_ovf, c_ovf};
`ifdef PERIOD_METER_DUTY_EN
            d_duty  = '{a_duty, b_duty, c_duty};
`else
            d_duty  = '{1'b0, 1'b0, 1'b0};
`endif
            for (int i = 0; i < NI; i++) begin
                check({nm[i], ".period"}, d_per[i],  m_per[i]);
                check({nm[i], ".high"},   d_high[i], m_high[i]);
                check({nm[i], ".valid"},  32'(d_valid[i]), 32'(m_valid[i]));
                check({nm[i], ".locked"}, 32'(d_lock[i]),  32'(m_lock[i]));
                check({nm[i], ".overflow"}, 32'(d_ovf[i]), 32'(m_ovf[i]));
`ifdef PERIOD_METER_DUTY_EN
                check({nm[i], ".duty_ok"}, 32'(d_duty[i]), 32'(m_duty[i]));
`endif
                if (d_valid[i] === 1'b1) vcnt[i]++;
            end
        end
    end

    task automatic seg(input int hi, input int lo);
        sig = 1'b1;
        repeat (hi) @(negedge clk);
        sig = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Directed stimulus with hand-computed literal checks.
    initial begin
        int v;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle low: nothing measured, no overflow even at CNT_W=6.
        repeat (100) @(negedge clk);
        #1;
        check("idle_a_period", 32'(a_per), 32'd0);
        check("idle_c_overflow", 32'(c_ovf), 32'd0);
        check("idle_a_locked", 32'(a_lock), 32'd0);

        // 5 high / 5 low
        repeat (8) seg(5, 5);
        #1;
        check("p10_a_period", 32'(a_per), 32'd10);
        check("p10_a_high", 32'(a_high), 32'd5);
        check("p10_a_locked", 32'(a_lock), 32'd1);
        check("p10_b_locked", 32'(b_lock), 32'd0);
        check("p10_c_locked", 32'(c_lock), 32'd1);

        // Latency: rising sample at posedge N, valid visible only after N+2.
        sig = 1'b1;
        @(posedge clk); @(negedge clk);
        check("lat_n0_valid", 32'(a_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_n1_valid", 32'(a_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_n2_valid", 32'(a_valid), 32'd1);
        repeat (2) @(negedge clk);
        sig = 1'b0;
        repeat (5) @(negedge clk);

        // 6 high / 6 low: a unlocks, b (EXPECTED=12) relocks.
        repeat (7) seg(6, 6);
        #1;
        check("p12_a_period", 32'(a_per), 32'd12);
        check("p12_a_high", 32'(a_high), 32'd6);
        check("p12_a_locked", 32'(a_lock), 32'd0);
        check("p12_b_locked", 32'(b_lock), 32'd1);

        // Tolerance on c: periods 9, 11, 10, 11 lock; then 12 unlocks.
        seg(4, 5); seg(5, 6); seg(5, 5); seg(5, 6);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("tol_c_period11", 32'(c_per), 32'd11);
        check("tol_c_locked", 32'(c_lock), 32'd1);
        repeat (2) @(negedge clk);
        sig = 1'b0;
        repeat (6) @(negedge clk);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("tol_c_period12", 32'(c_per), 32'd12);
        check("tol_c_unlocked", 32'(c_lock), 32'd0);
        repeat (2) @(negedge clk);
        sig = 1'b0;
        repeat (5) @(negedge clk);

        // Stuck high: c (CNT_W=6) overflows, 16-bit instances do not.
        sig = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("ovf_c_overflow", 32'(c_ovf), 32'd1);
        check("ovf_c_locked", 32'(c_lock), 32'd0);
        check("ovf_a_overflow", 32'(a_ovf), 32'd0);
        sig = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        v = vcnt[2];
        repeat (3) seg(5, 5);
        repeat (4) @(negedge clk);
        #1;
        check("ovf_c_resume_valids", 32'(vcnt[2] - v), 32'd2);
        check("ovf_c_sticky", 32'(c_ovf), 32'd1);

        // Reset mid-period while locked.
        repeat (6) seg(5, 5);
        #1;
        check("rst_a_locked_before", 32'(a_lock), 32'd1);
        sig = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sig = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_a_period", 32'(a_per), 32'd0);
        check("rst_a_locked", 32'(a_lock), 32'd0);
        check("rst_c_overflow", 32'(c_ovf), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        v = vcnt[0];
        seg(5, 5);
        #1;
        check("rst_first_rise_valids", 32'(vcnt[0] - v), 32'd0);
        seg(5, 5);
        #1;
        check("rst_second_rise_valids", 32'(vcnt[0] - v), 32'd1);

`ifdef PERIOD_METER_DUTY_EN
        // 3 high / 7 low: period fits EXPECTED but duty fails, never locks.
        repeat (8) seg(3, 7);
        #1;
        check("duty_a_period", 32'(a_per), 32'd10);
        check("duty_a_ok", 32'(a_duty), 32'd0);
        check("duty_a_locked", 32'(a_lock), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
